// File: rtl/jac1_seq_pkg.sv
// JAC1 sequencer shared definitions: state encoding and default widths.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package jac1_seq_pkg;

   localparam int STATE_W       = 3;
   localparam int PC_WIDTH_DEF  = 8;
   localparam int CNT_WIDTH_DEF = 16;

   typedef enum logic [STATE_W-1:0] {
      ST_HALT   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4
   } state_t;

endpackage

// File: rtl/jac1_step_edge.sv
// Rising-edge detector for the debug single-step request.
// Latency: combinational edge output, one flop of history.
// Backpressure: none; edges not consumed by the sequencer are simply lost.
module jac1_step_edge (
   input  logic clk,
   input  logic res_n,
   input  logic step_req,
   output logic step_edge
);

   logic step_q;

   // Remember last cycle's step_req level
   always_ff @(posedge clk) begin
      if (!res_n) begin
         step_q <= 1'b0;
      end else begin
         step_q <= step_req;
      end
   end

   assign step_edge = step_req & ~step_q;

endmodule

// File: rtl/jac1_seq_ctrl.sv
// JAC1 instruction sequencer: FETCH/DECODE/EXEC/WB with run/halt, single-step, PC breakpoint.
// Latency: 4 cycles per instruction; first FETCH one cycle after run/step accepted in HALT.
// Backpressure: none; run_req low halts after the current instruction's WB.
module jac1_seq_ctrl
   import jac1_seq_pkg::*;
#(
   parameter int PC_WIDTH  = PC_WIDTH_DEF,
   parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 res_n,
   input  logic                 run_req,
   input  logic                 step_req,
   input  logic                 bp_en,
   input  logic [PC_WIDTH-1:0]  bp_addr,
   input  logic [PC_WIDTH-1:0]  pc,
   input  logic                 dec_wr_en,
   input  logic                 dec_cnt_wr_en,
   output logic                 ir_load_en,
   output logic                 pc_inc_en,
   output logic                 pc_load_en,
   output logic                 rf_wr_en,
   output logic                 halted,
   output logic                 bp_hit,
   output logic [STATE_W-1:0]   state,
   output logic                 step_ack,
   output logic [CNT_WIDTH-1:0] instr_cnt
);

   state_t               state_q;
   logic                 step_mode_q;
   logic                 bp_skip_q;
   logic                 bp_hit_q;
   logic                 step_ack_q;
   logic [CNT_WIDTH-1:0] instr_cnt_q;
   logic                 step_edge;
   logic                 bp_match;

   jac1_step_edge u_step_edge (
      .clk       (clk),
      .res_n     (res_n),
      .step_req  (step_req),
      .step_edge (step_edge)
   );

   // A breakpoint fires only on a fresh visit, never on the PC we just resumed from
   assign bp_match = bp_en && (pc == bp_addr) && !bp_skip_q;

   // Sequencer state, debug flags and retired-instruction counter
   always_ff @(posedge clk) begin
      if (!res_n) begin
         state_q     <= ST_HALT;
         step_mode_q <= 1'b0;
         bp_skip_q   <= 1'b0;
         bp_hit_q    <= 1'b0;
         step_ack_q  <= 1'b0;
         instr_cnt_q <= '0;
      end else begin
         step_ack_q <= 1'b0;
         case (state_q)
            ST_HALT: begin
               if (run_req) begin
                  state_q   <= ST_FETCH;
                  bp_skip_q <= 1'b1;
                  bp_hit_q  <= 1'b0;
               end else if (step_edge) begin
                  state_q     <= ST_FETCH;
                  step_mode_q <= 1'b1;
                  bp_skip_q   <= 1'b1;
                  bp_hit_q    <= 1'b0;
               end
            end
            ST_FETCH: begin
               if (bp_match) begin
                  state_q  <= ST_HALT;
                  bp_hit_q <= 1'b1;
               end else begin
                  state_q   <= ST_DECODE;
                  bp_skip_q <= 1'b0;
               end
            end
            ST_DECODE: state_q <= ST_EXEC;
            ST_EXEC:   state_q <= ST_WB;
            ST_WB: begin
               if (instr_cnt_q != {CNT_WIDTH{1'b1}}) begin
                  instr_cnt_q <= instr_cnt_q + 1'b1;
               end
               if (step_mode_q) begin
                  step_ack_q  <= 1'b1;
                  step_mode_q <= 1'b0;
                  state_q     <= ST_HALT;
               end else if (!run_req) begin
                  state_q <= ST_HALT;
               end else begin
                  state_q <= ST_FETCH;
               end
            end
            default: state_q <= ST_HALT;
         endcase
      end
   end

   // Strobes decode the registered state; WB strobes are gated only by the decoder
   assign ir_load_en = (state_q == ST_FETCH) && !bp_match;
   assign pc_load_en = (state_q == ST_WB) && dec_cnt_wr_en;
   assign pc_inc_en  = (state_q == ST_WB) && !dec_cnt_wr_en;
   assign rf_wr_en   = (state_q == ST_WB) && dec_wr_en;
   assign halted     = (state_q == ST_HALT);
   assign bp_hit     = bp_hit_q;
   assign state      = state_q;
   assign step_ack   = step_ack_q;
   assign instr_cnt  = instr_cnt_q;

endmodule

// File: doc/jac1_seq_ctrl.md
Name: jac1_seq_ctrl

Overview:
Multi-cycle instruction sequencer for the JAC1 8-bit core. It sits between the program counter, program memory, decoder and register set, and sequences each instruction through FETCH, DECODE, EXEC and WB. It generates the PC advance/load strobes, the IR load strobe and the gated register write strobe. It also provides run/halt, single-step and one PC breakpoint for debug.

Parameters:
PC_WIDTH, 8, program counter / breakpoint address width
CNT_WIDTH, 16, retired-instruction counter width

Ports:
clk  in  1  system clock, all state updates on rising edge
res_n  in  1  reset; synchronous, active-low
run_req  in  1  level; 1 = free-run, 0 = halt after current instruction
step_req  in  1  rising edge requests one instruction while halted
bp_en  in  1  breakpoint enable
bp_addr  in  PC_WIDTH  breakpoint PC value
pc  in  PC_WIDTH  current program counter
dec_wr_en  in  1  decoder register-write request
dec_cnt_wr_en  in  1  decoder jump request (PC load from literal)
ir_load_en  out  1  load instruction register
pc_inc_en  out  1  PC increment strobe
pc_load_en  out  1  PC jump-load strobe
rf_wr_en  out  1  gated register-file write
halted  out  1  1 while in HALT
bp_hit  out  1  sticky breakpoint-hit flag
state  out  3  current state encoding
step_ack  out  1  one-cycle pulse when a stepped instruction retires
instr_cnt  out  CNT_WIDTH  retired instructions, saturating

Behaviour:
- Reset (res_n=0 at a clk edge): state=HALT, halted=1, bp_hit=0, step_ack=0, instr_cnt=0, step_mode=0, bp_skip=0, step edge-detect flop=0, all strobes 0. Reset asserted mid-instruction abandons it: no WB strobes are issued.
- States and encodings: HALT=0, FETCH=1, DECODE=2, EXEC=3, WB=4. Encodings 5–7 are illegal and go to HALT next cycle.
- step_req is edge-detected by registering its prior value. A rising edge outside HALT is dropped.
- HALT:
  - run_req=1 -> FETCH, bp_skip=1, bp_hit cleared.
  - Else step edge -> FETCH, step_mode=1, bp_skip=1, bp_hit cleared.
  - run_req has priority over a simultaneous step edge.
- FETCH:
  - bp_en=1 and pc==bp_addr and bp_skip=0 -> HALT, bp_hit=1, ir_load_en=0.
  - Otherwise ir_load_en=1 -> DECODE, bp_skip=0.
- DECODE: -> EXEC. No strobes.
- EXEC: -> WB. No strobes; ALU result settles.
- WB:
  - rf_wr_en=dec_wr_en.
  - pc_load_en=dec_cnt_wr_en; pc_inc_en=!dec_cnt_wr_en. PC load and increment are mutually exclusive.
  - instr_cnt increments and saturates at all-ones.
  - step_mode=1 -> step_ack=1, step_mode=0, go to HALT.
  - Else run_req=0 -> HALT.
  - Else -> FETCH.
- Strobes are Moore/Mealy decodes of the registered state. WB strobes are gated only by the decoder inputs.
- Latency:
  - 4 cycles per instruction.
  - The first FETCH is 1 cycle after run_req is sampled high in HALT.
  - run_req dropping mid-instruction completes that instruction through WB, then halts.
- halted = (state==HALT).
- A breakpoint at the PC where execution resumes does not re-trigger (bp_skip). The next visit does trigger.

Decomposition:
- Package jac1_seq_pkg holds:
  - state encoding constants (HALT..WB) and the 3-bit state width
  - default widths PC_WIDTH=8 and CNT_WIDTH=16
- One sub-module, jac1_step_edge, contains the step_req edge detector (flop plus AND-NOT, synchronous active-low reset).
- The rest stays in a single FSM module.

Test Plan:
1. Reset hold 3 cycles, then run_req=1 with dec_wr_en=1 and dec_cnt_wr_en=0 -> state sequence 0,1,2,3,4,1…; ir_load_en high on cycles 1,5,9; rf_wr_en and pc_inc_en high on cycles 4,8; instr_cnt=2 after 8 cycles.
2. Halted, pulse step_req for 1 cycle -> exactly one FETCH..WB pass; step_ack=1 in the cycle after WB, then HALT. A step_req held high for 10 cycles still yields one instruction.
3. run_req=1, bp_en=1, bp_addr=8'h05, pc reaches 8'h05 at FETCH -> HALT next cycle, bp_hit=1, no ir_load_en. Reassert run_req -> FETCH proceeds at pc 8'h05 and bp_hit clears.
4. In WB with dec_cnt_wr_en=1 -> pc_load_en=1 and pc_inc_en=0. With dec_wr_en=0 -> rf_wr_en=0.
5. Drop run_req in DECODE -> EXEC and WB still occur and instr_cnt increments, then HALT with halted=1.
6. Assert res_n=0 in EXEC -> next cycle state=0, no WB strobes, instr_cnt=0. Force instr_cnt to 16'hFFFF and retire one instruction -> it stays at 16'hFFFF.
